memory_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/data_memory_array.sv | 26 ++
 rtl/memory_stage.sv | 152 +++++++++++++++
 tb/tb_memory_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the pipeline memory stage.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_e;

endpackage

// File: rtl/data_memory_array.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_memory_array
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Store commits on the clock edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: data memory access with wait states, branch resolve, MEM/WB register.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] PC_next_Exe,
    input  logic [REG_W-1:0]  Exe_rd,
    input  logic [WORD_W-1:0] ALU_result_Exe,
    input  logic [WORD_W-1:0] read_data_2_Exe,
    input  logic              zero_Exe,
    input  logic              Memwrite_Exe,
    input  logic              Memread_Exe,
    input  logic              Regwrite_Exe,
    input  logic              Branch_Exe,
    input  logic              MemtoReg_Exe,
    input  logic              jump_Exe,
    output logic              PCSrc,
    output logic [WORD_W-1:0] branch_target,
    output logic              stall_mem,
    output logic [REG_W-1:0]  Mem_rd,
    output logic [WORD_W-1:0] ALU_result_Mem,
    output logic [WORD_W-1:0] read_data_Mem,
    output logic              Regwrite_Mem,
    output logic              MemtoReg_Mem
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // The IDLE request cycle is the first stall cycle, so BUSY starts with one fewer remaining.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic             HAS_WAIT = (WAIT_CYCLES != 0);
    localparam logic             HAS_BUSY = (WAIT_CYCLES > 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [REG_W-1:0]  mem_rd_q, mem_rd_d;
    logic [WORD_W-1:0] alu_result_q, alu_result_d;
    logic [WORD_W-1:0] read_data_q, read_data_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;

    logic              access;
    logic              mem_we;
    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] load_data;
    logic              unused_addr_bits;

    assign access   = Memread_Exe | Memwrite_Exe;
    assign word_idx = ALU_result_Exe[IDX_W+1:2];

    // Byte offset and bits above the array size are deliberately ignored (address wraps).
    assign unused_addr_bits = ^{ALU_result_Exe[WORD_W-1:IDX_W+2], ALU_result_Exe[1:0]};

    assign PCSrc         = (Branch_Exe & zero_Exe) | jump_Exe;
    assign branch_target = PC_next_Exe;

    // Stall decode: registered BUSY state plus a fresh request seen in IDLE.
    always_comb begin
        stall_mem = (state_q == StBusy) | ((state_q == StIdle) & access & HAS_WAIT);
    end

    // Store commits only when the access completes; never while reset is held.
    assign mem_we = Memwrite_Exe & ~stall_mem & rst_n;

    data_memory_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (word_idx),
        .wdata_i (read_data_2_Exe),
        .rdata_o (mem_rdata)
    );

    // Only a pure load returns memory data; conflicting read+write and non-loads give 0.
    assign load_data = (Memread_Exe & ~Memwrite_Exe) ? mem_rdata : '0;

    // Wait-state FSM next state; cnt holds remaining stall cycles including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (access && HAS_WAIT) begin
                    cnt_d   = CNT_INIT;
                    state_d = HAS_BUSY ? StBusy : StDone;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // MEM/WB next value: bubble while stalled, otherwise the completing instruction.
    always_comb begin
        mem_rd_d     = '0;
        alu_result_d = '0;
        read_data_d  = '0;
        regwrite_d   = 1'b0;
        memtoreg_d   = 1'b0;
        if (!stall_mem) begin
            mem_rd_d     = Exe_rd;
            alu_result_d = ALU_result_Exe;
            read_data_d  = load_data;
            regwrite_d   = Regwrite_Exe;
            memtoreg_d   = MemtoReg_Exe;
        end
    end

    // FSM, wait counter and MEM/WB state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_rd_q     <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_rd_q     <= mem_rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
        end
    end

    assign Mem_rd         = mem_rd_q;
    assign ALU_result_Mem = alu_result_q;
    assign read_data_Mem  = read_data_q;
    assign Regwrite_Mem   = regwrite_q;
    assign MemtoReg_Mem   = memtoreg_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: zero-wait instance driven from a vector table, three-wait instance
// driven by hand-written sequences; MEM/WB results checked through a scoreboard queue.
module tb_memory_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        zero;
        logic        mw;
        logic        mr;
        logic        rw;
        logic        br;
        logic        m2r;
        logic        jmp;
    } ex_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic        m2r;
    } wb_t;

    typedef struct {
        ex_t         ex;
        logic        pcsrc;
        wb_t         wb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ex_t  in0 = '0;
    ex_t  in3 = '0;

    logic        pcsrc0, stall0, rw0, m2r0;
    logic [31:0] tgt0, alu0, rdata0;
    logic [4:0]  rd0;
    logic        pcsrc3, stall3, rw3, m2r3;
    logic [31:0] tgt3, alu3, rdata3;
    logic [4:0]  rd3;

    int tests = 0;
    int fails = 0;
    wb_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    memory_stage #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .PC_next_Exe(in0.pc), .Exe_rd(in0.rd), .ALU_result_Exe(in0.alu),
        .read_data_2_Exe(in0.wdata), .zero_Exe(in0.zero), .Memwrite_Exe(in0.mw),
        .Memread_Exe(in0.mr), .Regwrite_Exe(in0.rw), .Branch_Exe(in0.br),
        .MemtoReg_Exe(in0.m2r), .jump_Exe(in0.jmp),
        .PCSrc(pcsrc0), .branch_target(tgt0), .stall_mem(stall0), .Mem_rd(rd0),
        .ALU_result_Mem(alu0), .read_data_Mem(rdata0), .Regwrite_Mem(rw0),
        .MemtoReg_Mem(m2r0)
    );

    memory_stage #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .PC_next_Exe(in3.pc), .Exe_rd(in3.rd), .ALU_result_Exe(in3.alu),
        .read_data_2_Exe(in3.wdata), .zero_Exe(in3.zero), .Memwrite_Exe(in3.mw),
        .Memread_Exe(in3.mr), .Regwrite_Exe(in3.rw), .Branch_Exe(in3.br),
        .MemtoReg_Exe(in3.m2r), .jump_Exe(in3.jmp),
        .PCSrc(pcsrc3), .branch_target(tgt3), .stall_mem(stall3), .Mem_rd(rd3),
        .ALU_result_Mem(alu3), .read_data_Mem(rdata3), .Regwrite_Mem(rw3),
        .MemtoReg_Mem(m2r3)
    );

    function automatic ex_t op(input logic mr, input logic mw, input logic rw, input logic m2r,
                               input logic br, input logic zero, input logic jmp,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] wdata, input logic [31:0] pc);
        ex_t e;
        e.mr = mr; e.mw = mw; e.rw = rw; e.m2r = m2r; e.br = br; e.zero = zero; e.jmp = jmp;
        e.rd = rd; e.alu = alu; e.wdata = wdata; e.pc = pc;
        return e;
    endfunction

    function automatic wb_t wb(input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic rw, input logic m2r);
        wb_t w;
        w.rd = rd; w.alu = alu; w.rdata = rdata; w.rw = rw; w.m2r = m2r;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop the oldest expected MEM/WB record and compare against the chosen instance.
    task automatic check_wb(input bit sel, input string name);
        wb_t e;
        wb_t a;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got no expectation", name);
        end else begin
            e = sb.pop_front();
            a = sel ? wb(rd3, alu3, rdata3, rw3, m2r3) : wb(rd0, alu0, rdata0, rw0, m2r0);
            chk({name, " Mem_rd"}, 32'(a.rd), 32'(e.rd));
            chk({name, " ALU_result_Mem"}, a.alu, e.alu);
            chk({name, " read_data_Mem"}, a.rdata, e.rdata);
            chk({name, " Regwrite_Mem"}, 32'(a.rw), 32'(e.rw));
            chk({name, " MemtoReg_Mem"}, 32'(a.m2r), 32'(e.m2r));
        end
    endtask

    // One access on the three-wait instance: count stall cycles, check bubbles, then result.
    task automatic access3(input ex_t ex, input wb_t exp, input string name);
        int n;
        n = 0;
        @(negedge clk);
        in3 = ex;
        sb.push_back(exp);
        for (int k = 0; k < 12; k++) begin
            #1;
            if (!stall3) break;
            n++;
            @(posedge clk);
            #1;
            chk({name, " bubble Regwrite_Mem"}, 32'(rw3), 32'd0);
            chk({name, " bubble Mem_rd"}, 32'(rd3), 32'd0);
            @(negedge clk);
        end
        chk({name, " stall cycles"}, 32'(n), 32'd3);
        @(posedge clk);
        #1;
        check_wb(1'b1, name);
        // Inputs still request an access, so the next stall starts right after DONE.
        chk({name, " stall restarts"}, 32'(stall3), 32'd1);
        @(negedge clk);
        in3 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h4), 1'b0,
                     wb(5'd0, 32'h10, 32'h0, 1'b0, 1'b0)};
        vecs[1]  = '{op(1, 0, 1, 1, 0, 0, 0, 5'd5, 32'h10, 32'h0, 32'h8), 1'b0,
                     wb(5'd5, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1)};
        vecs[2]  = '{op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h400, 32'h12345678, 32'h0), 1'b0,
                     wb(5'd0, 32'h400, 32'h0, 1'b0, 1'b0)};
        vecs[3]  = '{op(1, 0, 1, 1, 0, 0, 0, 5'd6, 32'h0, 32'h0, 32'h0), 1'b0,
                     wb(5'd6, 32'h0, 32'h12345678, 1'b1, 1'b1)};
        vecs[4]  = '{op(1, 0, 1, 1, 0, 0, 0, 5'd7, 32'h3, 32'h0, 32'h0), 1'b0,
                     wb(5'd7, 32'h3, 32'h12345678, 1'b1, 1'b1)};
        vecs[5]  = '{op(0, 0, 1, 0, 1, 1, 0, 5'd8, 32'h55, 32'h0, 32'h80), 1'b1,
                     wb(5'd8, 32'h55, 32'h0, 1'b1, 1'b0)};
        vecs[6]  = '{op(0, 0, 1, 0, 1, 0, 0, 5'd8, 32'h55, 32'h0, 32'h80), 1'b0,
                     wb(5'd8, 32'h55, 32'h0, 1'b1, 1'b0)};
        vecs[7]  = '{op(0, 0, 1, 0, 0, 0, 1, 5'd31, 32'h1234, 32'h0, 32'h200), 1'b1,
                     wb(5'd31, 32'h1234, 32'h0, 1'b1, 1'b0)};
        vecs[8]  = '{op(1, 1, 1, 1, 0, 0, 0, 5'd9, 32'h8, 32'hA5A5A5A5, 32'h0), 1'b0,
                     wb(5'd9, 32'h8, 32'h0, 1'b1, 1'b1)};
        vecs[9]  = '{op(1, 0, 1, 1, 0, 0, 0, 5'd10, 32'h8, 32'h0, 32'h0), 1'b0,
                     wb(5'd10, 32'h8, 32'hA5A5A5A5, 1'b1, 1'b1)};
        vecs[10] = '{op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h7FC, 32'h0BADF00D, 32'h0), 1'b0,
                     wb(5'd0, 32'h7FC, 32'h0, 1'b0, 1'b0)};
        vecs[11] = '{op(1, 0, 1, 1, 0, 0, 0, 5'd12, 32'h3FC, 32'h0, 32'h0), 1'b0,
                     wb(5'd12, 32'h3FC, 32'h0BADF00D, 1'b1, 1'b1)};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall0", 32'(stall0), 32'd0);
        chk("reset stall3", 32'(stall3), 32'd0);
        sb.push_back(wb(5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
        check_wb(1'b0, "reset dut0");
        sb.push_back(wb(5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
        check_wb(1'b1, "reset dut3");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait table: single-cycle latency, no stall, same-cycle branch resolve.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in0 = vecs[i].ex;
            #1;
            chk($sformatf("vec%0d PCSrc", i), 32'(pcsrc0), 32'(vecs[i].pcsrc));
            chk($sformatf("vec%0d branch_target", i), tgt0, vecs[i].ex.pc);
            chk($sformatf("vec%0d stall_mem", i), 32'(stall0), 32'd0);
            sb.push_back(vecs[i].wb);
            @(posedge clk);
            #1;
            check_wb(1'b0, $sformatf("vec%0d", i));
        end

        // Three-wait instance: store then load.
        access3(op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h20, 32'hCAFEF00D, 32'h0),
                wb(5'd0, 32'h20, 32'h0, 1'b0, 1'b0), "w3 store");
        access3(op(1, 0, 1, 1, 0, 0, 0, 5'd5, 32'h20, 32'h0, 32'h0),
                wb(5'd5, 32'h20, 32'hCAFEF00D, 1'b1, 1'b1), "w3 load");

        // Branch output stays valid while stalled.
        @(negedge clk);
        in3 = op(1, 0, 1, 1, 1, 1, 0, 5'd3, 32'h20, 32'h0, 32'h90);
        #1;
        chk("w3 stall with branch", 32'(stall3), 32'd1);
        chk("w3 PCSrc during stall", 32'(pcsrc3), 32'd1);
        chk("w3 target during stall", tgt3, 32'h90);
        @(negedge clk);
        in3 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-BUSY abandons the pending store.
        @(negedge clk);
        in3 = op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h20, 32'h11111111, 32'h0);
        @(posedge clk);
        #1;
        chk("busy before reset", 32'(stall3), 32'd1);
        #2;
        rst_n = 1'b0;
        in3 = '0;
        #1;
        chk("async reset stall3", 32'(stall3), 32'd0);
        sb.push_back(wb(5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
        check_wb(1'b0, "async reset dut0");
        sb.push_back(wb(5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
        check_wb(1'b1, "async reset dut3");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access3(op(1, 0, 1, 1, 0, 0, 0, 5'd5, 32'h20, 32'h0, 32'h0),
                wb(5'd5, 32'h20, 32'hCAFEF00D, 1'b1, 1'b1), "w3 load after reset");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
